reg_verify_ctrl: RTL

//  Synthesizable on-board counterpart of the simulation register checker.
//  - Holds the processor in reset, releases it, and lets it run a programmed number of cycles.
//  - Then takes over regfile read port A through the existing test-mode rs1 mux.
//  - Reads r0..r31 in order and compares each against an expected-value ROM.
//  - Streams every result out on a valid/ready port (e.g. to a UART formatter).
//  - Reports the final pass/fail and the error count.

---
 rtl/reg_verify_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/reg_verify_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_verify_ctrl
//  Purpose  : On-board register checker. Resets and runs the processor for a
//             programmed number of cycles, then reads r0..r31 through the
//             test-mode rs1 mux, compares each against an expected-value ROM
//             and streams every result on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_verify_ctrl #(
  parameter int DATA_W     = 32,
  parameter int CYC_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  output logic              cpu_reset,
  output logic              test_mode,
  output logic [4:0]        test_reg,
  input  logic [DATA_W-1:0] reg_data,
  output logic [4:0]        exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_exp,
  output logic              out_match,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [5:0]        err_count
);

  localparam logic [CYC_W-1:0] C_RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [4:0]       C_LAST_REG = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_READ = 3'd3,
    S_CMP  = 3'd4,
    S_EMIT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CYC_W-1:0] r_cnt;
  logic [CYC_W-1:0] r_num;
  logic [4:0]       r_index;

  // The index addresses both the regfile mux and the ROM, so the two stay
  // aligned and constant for the whole READ/CMP/EMIT of one register.
  assign test_reg = r_index;
  assign exp_addr = r_index;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection and state-decoded control outputs.
  always_comb begin
    w_next    = r_state;
    cpu_reset = 1'b0;
    test_mode = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    pass      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        busy      = 1'b0;
        if (start) w_next = S_RST;
      end
      S_RST: begin
        cpu_reset = 1'b1;
        if (r_cnt == C_RST_LAST)
          w_next = (r_num == '0) ? S_READ : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == r_num - CYC_W'(1)) w_next = S_READ;
      end
      S_READ: begin
        test_mode = 1'b1;
        w_next    = S_CMP;
      end
      S_CMP: begin
        test_mode = 1'b1;
        w_next    = S_EMIT;
      end
      S_EMIT: begin
        test_mode = 1'b1;
        if (out_ready) w_next = (r_index == C_LAST_REG) ? S_DONE : S_READ;
      end
      S_DONE: begin
        test_mode = 1'b1;
        busy      = 1'b0;
        done      = 1'b1;
        pass      = (err_count == 6'd0);
        if (start) w_next = S_RST;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Counters, register index, result beat and error tally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_num     <= '0;
      r_index   <= '0;
      out_valid <= 1'b0;
      out_reg   <= '0;
      out_data  <= '0;
      out_exp   <= '0;
      out_match <= 1'b0;
      err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num     <= num_cycles;
            r_cnt     <= '0;
            r_index   <= '0;
            err_count <= '0;
          end
        end
        S_RST: begin
          r_cnt <= (r_cnt == C_RST_LAST) ? '0 : r_cnt + CYC_W'(1);
        end
        S_RUN: begin
          r_cnt <= r_cnt + CYC_W'(1);
        end
        S_CMP: begin
          out_valid <= 1'b1;
          out_reg   <= r_index;
          out_data  <= reg_data;
          out_exp   <= exp_data;
          out_match <= (reg_data == exp_data);
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err_count <= err_count + {5'd0, ~out_match};
            if (r_index != C_LAST_REG) r_index <= r_index + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
